// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the pong game sequencer: game-phase encodings (these
// values appear directly on the game_state output for the text overlay), the
// BCD score record, default game parameters, and the BCD increment helper.
// -----------------------------------------------------------------------------
package pong_pkg;

    localparam int unsigned BCD_W           = 4;
    localparam int unsigned LIVES_DEF       = 3;
    localparam int unsigned WAIT_FRAMES_DEF = 120;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'b00,
        ST_PLAY    = 2'b01,
        ST_NEWBALL = 2'b10,
        ST_OVER    = 2'b11
    } state_e;

    typedef struct packed {
        logic [BCD_W-1:0] d1;  // tens
        logic [BCD_W-1:0] d0;  // units
    } score_t;

    // Two-digit BCD increment. 99 wraps to 00.
    function automatic score_t bcd_inc(input score_t s);
        score_t r;
        r = s;
        if (s.d0 == 4'd9) begin
            r.d0 = 4'd0;
            r.d1 = (s.d1 == 4'd9) ? 4'd0 : s.d1 + 4'd1;
        end else begin
            r.d0 = s.d0 + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pong_btn_debounce.sv
// -----------------------------------------------------------------------------
// pong_btn_debounce
// Single-bit debouncer. The output level follows the (already synchronised)
// input only after the input has disagreed with the current output for
// DB_TICKS consecutive clocks; any shorter excursion is dropped.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (output level resets to 0)
//   din_i    in   synchronised raw button level
//   level_o  out  debounced button level
// -----------------------------------------------------------------------------
module pong_btn_debounce #(
    parameter int unsigned DB_TICKS = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_i,
    output logic level_o
);

    localparam int unsigned CW = (DB_TICKS < 2) ? 1 : $clog2(DB_TICKS + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    // Counter only runs while input and accepted level disagree, so a glitch
    // that returns to the old level restarts the stability window from zero.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (din_i != level_q) begin
            if (cnt_q == CW'(DB_TICKS - 1)) begin
                level_d = din_i;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// pong_game_ctrl
// Game sequencer for the VGA pong design: tracks the game phase, BCD score and
// remaining balls, and drives freeze/serve controls to the graphics unit.
// Optional feature macro: DEBOUNCE_EN -- when defined, each synchronised
// button bit is also debounced (DB_TICKS stable clocks) before edge detection.
// Ports:
//   CLK_50MHZ    in   system clock, rising edge
//   RESET        in   asynchronous active-low reset
//   btn[1:0]     in   raw paddle buttons, active-high
//   frame_tick   in   1-clock pulse per frame
//   hit          in   1-clock pulse, ball struck paddle
//   miss         in   1-clock pulse, ball passed paddle
//   ball_reset   out  hold ball at serve position (registered)
//   graph_still  out  freeze ball/paddle motion (registered)
//   game_state   out  current phase (pong_pkg::state_e encoding)
//   score_d1/d0  out  BCD score digits
//   lives_left   out  balls remaining including the one in play
// -----------------------------------------------------------------------------
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned LIVES       = LIVES_DEF,
    parameter int unsigned WAIT_FRAMES = WAIT_FRAMES_DEF,
    parameter int unsigned DB_TICKS    = 500000
) (
    input  logic             CLK_50MHZ,
    input  logic             RESET,
    input  logic [1:0]       btn,
    input  logic             frame_tick,
    input  logic             hit,
    input  logic             miss,
    output logic             ball_reset,
    output logic             graph_still,
    output logic [1:0]       game_state,
    output logic [BCD_W-1:0] score_d1,
    output logic [BCD_W-1:0] score_d0,
    output logic [1:0]       lives_left
);

    localparam int unsigned TW = $clog2(WAIT_FRAMES + 1);

    if (LIVES < 1 || LIVES > 3) begin : g_bad_lives
        $error("pong_game_ctrl: LIVES must be 1..3");
    end
    if (DB_TICKS < 1) begin : g_bad_db
        $error("pong_game_ctrl: DB_TICKS must be at least 1");
    end

    // ---------------- button conditioning ----------------
    logic [1:0] sync1_q, sync2_q;
    logic       btn_level;
    logic       level_q;
    logic       press;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its source; blocking here would collapse the
    // two-stage synchroniser into a single flop.
    always_ff @(posedge CLK_50MHZ or negedge RESET) begin
        if (!RESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

`ifdef DEBOUNCE_EN
    logic [1:0] db_level;

    for (genvar i = 0; i < 2; i++) begin : g_db
        pong_btn_debounce #(
            .DB_TICKS (DB_TICKS)
        ) u_db (
            .clk     (CLK_50MHZ),
            .rst_n   (RESET),
            .din_i   (sync2_q[i]),
            .level_o (db_level[i])
        );
    end

    assign btn_level = |db_level;
`else
    assign btn_level = |sync2_q;
`endif

    always_ff @(posedge CLK_50MHZ or negedge RESET) begin
        if (!RESET) begin
            level_q <= 1'b0;
        end else begin
            level_q <= btn_level;
        end
    end

    // Single-clock pulse on the rising edge of the combined button level.
    assign press = btn_level & ~level_q;

    // ---------------- FSM, score, lives, frame timer ----------------
    state_e          state_q, state_d;
    score_t          score_q, score_d;
    logic [1:0]      lives_q, lives_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            still_q, still_d;

    // NOTE: every signal driven here gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        lives_d = lives_q;
        timer_d = timer_q;

        unique case (state_q)
            ST_NEWGAME: begin
                if (press) begin
                    state_d = ST_PLAY;
                    score_d = '0;
                    lives_d = 2'(LIVES);
                end
            end
            ST_PLAY: begin
                // miss has priority over a simultaneous hit; the timer load
                // also overrides any frame_tick on this clock.
                if (miss) begin
                    lives_d = lives_q - 2'd1;
                    timer_d = TW'(WAIT_FRAMES);
                    state_d = (lives_q == 2'd1) ? ST_OVER : ST_NEWBALL;
                end else if (hit) begin
                    score_d = bcd_inc(score_q);
                end
            end
            ST_NEWBALL: begin
                // A press while the timer is still running is simply lost.
                if (timer_q == '0) begin
                    if (press) state_d = ST_PLAY;
                end else if (frame_tick) begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_OVER: begin
                if (timer_q == '0) begin
                    state_d = ST_NEWGAME;
                end else if (frame_tick) begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = ST_NEWGAME;
        endcase

        // Moore freeze/serve control, registered from the next state so it
        // changes on the same edge as game_state.
        still_d = (state_d != ST_PLAY);
    end

    always_ff @(posedge CLK_50MHZ or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_NEWGAME;
            score_q <= '0;
            lives_q <= 2'(LIVES);
            timer_q <= '0;
            still_q <= 1'b1;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            lives_q <= lives_d;
            timer_q <= timer_d;
            still_q <= still_d;
        end
    end

    assign game_state  = state_q;
    assign ball_reset  = still_q;
    assign graph_still = still_q;
    assign score_d1    = score_q.d1;
    assign score_d0    = score_q.d0;
    assign lives_left  = lives_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pong_game_ctrl
// Directed bench for pong_game_ctrl with WAIT_FRAMES=4, DB_TICKS=8, LIVES=3.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_pong_game_ctrl;

    localparam int unsigned LIVES       = 3;
    localparam int unsigned WAIT_FRAMES = 4;
    localparam int unsigned DB_TICKS    = 8;

`ifdef DEBOUNCE_EN
    localparam int HOLD   = DB_TICKS + 4;
    localparam int SETTLE = DB_TICKS + 6;
`else
    localparam int HOLD   = 1;
    localparam int SETTLE = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] btn;
    logic       frame_tick, hit, miss;
    logic       ball_reset, graph_still;
    logic [1:0] game_state;
    logic [3:0] score_d1, score_d0;
    logic [1:0] lives_left;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pong_game_ctrl #(
        .LIVES       (LIVES),
        .WAIT_FRAMES (WAIT_FRAMES),
        .DB_TICKS    (DB_TICKS)
    ) dut (
        .CLK_50MHZ   (clk),
        .RESET       (rst_n),
        .btn         (btn),
        .frame_tick  (frame_tick),
        .hit         (hit),
        .miss        (miss),
        .ball_reset  (ball_reset),
        .graph_still (graph_still),
        .game_state  (game_state),
        .score_d1    (score_d1),
        .score_d0    (score_d0),
        .lives_left  (lives_left)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One-clock pulse on any combination of hit/miss/frame_tick.
    task automatic pulse(input logic h, input logic m, input logic f);
        @(negedge clk);
        hit = h; miss = m; frame_tick = f;
        @(negedge clk);
        hit = 1'b0; miss = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic press_btn(input logic [1:0] b);
        @(negedge clk);
        btn = b;
        repeat (HOLD) @(negedge clk);
        btn = 2'b00;
        repeat (SETTLE) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_score(input string tag, input logic [3:0] d1, input logic [3:0] d0);
        check({tag, ".d1"}, {4'h0, score_d1}, {4'h0, d1});
        check({tag, ".d0"}, {4'h0, score_d0}, {4'h0, d0});
    endtask

    initial begin
        rst_n = 1'b0; btn = 2'b00; frame_tick = 1'b0; hit = 1'b0; miss = 1'b0;

        // 1. reset values
        idle(3);
        check("rst.state", {6'd0, game_state}, 8'd0);
        check_score("rst.score", 4'd0, 4'd0);
        check("rst.lives", {6'd0, lives_left}, 8'd3);
        check("rst.ball_reset", {7'd0, ball_reset}, 8'd1);
        check("rst.graph_still", {7'd0, graph_still}, 8'd1);
        rst_n = 1'b1;
        idle(2);

        // hit/miss ignored in NEWGAME
        pulse(1'b1, 1'b1, 1'b0);
        check_score("ng.hit_ignored", 4'd0, 4'd0);
        check("ng.miss_ignored", {6'd0, lives_left}, 8'd3);

        // 2. start game, 12 hits
        press_btn(2'b01);
        check("play.state", {6'd0, game_state}, 8'd1);
        check("play.ball_reset", {7'd0, ball_reset}, 8'd0);
        check("play.graph_still", {7'd0, graph_still}, 8'd0);
        for (int i = 0; i < 12; i++) pulse(1'b1, 1'b0, 1'b0);
        check_score("score12", 4'd1, 4'd2);

        // 3. up to 99, wrap, then simultaneous hit+miss
        for (int i = 0; i < 87; i++) pulse(1'b1, 1'b0, 1'b0);
        check_score("score99", 4'd9, 4'd9);
        pulse(1'b1, 1'b0, 1'b0);
        check_score("wrap00", 4'd0, 4'd0);
        pulse(1'b1, 1'b0, 1'b0);
        check_score("score01", 4'd0, 4'd1);
        pulse(1'b1, 1'b1, 1'b0);
        check_score("hitmiss.held", 4'd0, 4'd1);
        check("hitmiss.lives", {6'd0, lives_left}, 8'd2);
        check("hitmiss.state", {6'd0, game_state}, 8'd2);
        check("newball.ball_reset", {7'd0, ball_reset}, 8'd1);

        // 4. NEWBALL: early press dropped, press after 4th tick accepted
        pulse(1'b1, 1'b0, 1'b0);
        check_score("newball.hit_ignored", 4'd0, 4'd1);
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b0, 1'b1);
        press_btn(2'b01);
        check("newball.early_press", {6'd0, game_state}, 8'd2);
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b0, 1'b1);
        check("newball.timer0_wait", {6'd0, game_state}, 8'd2);
        press_btn(2'b10);
        check("newball.press", {6'd0, game_state}, 8'd1);

        // miss with frame_tick on the same clock: timer load wins, so three
        // further ticks are not enough to release the serve
        pulse(1'b0, 1'b1, 1'b1);
        check("load_wins.lives", {6'd0, lives_left}, 8'd1);
        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b0, 1'b1);
        press_btn(2'b01);
        check("load_wins.held", {6'd0, game_state}, 8'd2);
        pulse(1'b0, 1'b0, 1'b1);
        press_btn(2'b01);
        check("load_wins.play", {6'd0, game_state}, 8'd1);

        // 5. last miss -> OVER, timer -> NEWGAME with score kept
        pulse(1'b0, 1'b1, 1'b0);
        check("over.state", {6'd0, game_state}, 8'd3);
        check("over.lives", {6'd0, lives_left}, 8'd0);
        check("over.graph_still", {7'd0, graph_still}, 8'd1);
        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b0, 1'b1);
        check("over.hold", {6'd0, game_state}, 8'd3);
        pulse(1'b0, 1'b0, 1'b1);
        idle(1);
        check("over.to_newgame", {6'd0, game_state}, 8'd0);
        check_score("over.score_kept", 4'd0, 4'd1);
        check("over.lives_kept", {6'd0, lives_left}, 8'd0);
        press_btn(2'b01);
        check("restart.state", {6'd0, game_state}, 8'd1);
        check_score("restart.score", 4'd0, 4'd0);
        check("restart.lives", {6'd0, lives_left}, 8'd3);

        // asynchronous reset in the middle of play
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        check_score("pre_rst.score", 4'd0, 4'd2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.state", {6'd0, game_state}, 8'd0);
        check_score("midrst.score", 4'd0, 4'd0);
        check("midrst.graph_still", {7'd0, graph_still}, 8'd1);
        idle(2);
        rst_n = 1'b1;
        idle(2);

`ifdef DEBOUNCE_EN
        // 6. glitch shorter than DB_TICKS is dropped; a long hold is one press
        @(negedge clk);
        btn = 2'b01;
        idle(DB_TICKS - 3);
        btn = 2'b00;
        idle(DB_TICKS + 6);
        check("db.glitch", {6'd0, game_state}, 8'd0);
        @(negedge clk);
        btn = 2'b01;
        idle(DB_TICKS + 4);
        check("db.held", {6'd0, game_state}, 8'd1);
        btn = 2'b00;
        idle(DB_TICKS + 6);
        check("db.single", {6'd0, game_state}, 8'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
